// File: rtl/ifq.sv
// Instruction fetch queue: fetches 128-bit lines from the I-cache and hands out one 32-bit
// instruction per read. Optional perf counters are built when IFQ_PERF_EN is defined.
module ifq #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  cache_pc_in,
  output logic         cache_rd_en,
  input  logic [127:0] cache_dout,
  input  logic         cache_dout_valid,
  output logic [31:0]  ifq_inst,
  output logic [31:0]  ifq_pc_out,
  output logic         ifq_empty,
  input  logic         ifq_rd_en,
  input  logic         ifq_jump_branch_valid,
`ifdef IFQ_PERF_EN
  output logic [31:0]  ifq_perf_miss_cnt,
  output logic [31:0]  ifq_perf_flush_cnt,
`endif
  input  logic [31:0]  ifq_jump_branch_address
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  fetch_pc, read_pc;
  logic [AW:0]  wp, rp;
  logic [1:0]   rd_word;
  logic [127:0] line_mem [DEPTH];

  logic empty, full, do_wr, do_rd;
  logic unused_addr_bits;

  assign unused_addr_bits = ^ifq_jump_branch_address[1:0];

  // Extra wrap bit tells full from empty when the index bits match.
  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

  assign cache_pc_in = {fetch_pc[31:4], 4'b0};
  assign cache_rd_en = !full && !ifq_jump_branch_valid;
  assign do_wr       = cache_rd_en && cache_dout_valid;
  assign do_rd       = ifq_rd_en && !empty;

  assign ifq_inst   = line_mem[rp[AW-1:0]][{rd_word, 5'b0} +: 32];
  assign ifq_pc_out = read_pc + 32'd4;
  assign ifq_empty  = empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      read_pc  <= '0;
      wp       <= '0;
      rp       <= '0;
      rd_word  <= '0;
    end else if (ifq_jump_branch_valid) begin
      // Redirect: drop everything queued and restart mid-line at the target word.
      wp       <= '0;
      rp       <= '0;
      fetch_pc <= {ifq_jump_branch_address[31:4], 4'b0};
      read_pc  <= {ifq_jump_branch_address[31:2], 2'b0};
      rd_word  <= ifq_jump_branch_address[3:2];
    end else begin
      if (do_wr) begin
        wp       <= wp + 1'b1;
        fetch_pc <= fetch_pc + 32'd16;
      end
      if (do_rd) begin
        read_pc <= read_pc + 32'd4;
        rd_word <= rd_word + 2'd1;
        if (rd_word == 2'd3) rp <= rp + 1'b1;
      end
    end
  end

  // Line store carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) line_mem[wp[AW-1:0]] <= cache_dout;
  end

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ifq_perf_miss_cnt  <= '0;
      ifq_perf_flush_cnt <= '0;
    end else begin
      if (cache_rd_en && !cache_dout_valid && ifq_perf_miss_cnt != 32'hFFFF_FFFF)
        ifq_perf_miss_cnt <= ifq_perf_miss_cnt + 32'd1;
      if (ifq_jump_branch_valid && ifq_perf_flush_cnt != 32'hFFFF_FFFF)
        ifq_perf_flush_cnt <= ifq_perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
